bulk_in_scheduler: RTL and testbench

//   Services host IN tokens for bulk IN endpoints EP1..EP(NUM_EP) and shares the USB packet

---
 rtl/bulk_in_scheduler.sv | 170 +++++++++++++++++
 tb/tb_bulk_in_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bulk_in_scheduler.sv
// Bulk IN endpoint scheduler: answers IN tokens for EP1..EP(NUM_EP) with DATA0/1, NAK or STALL,
// shares the packet encoder between endpoint sources and commits or rewinds each packet.
module bulk_in_scheduler #(
  parameter int NUM_EP  = 2,
  parameter int TIMEOUT = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            usb_addr_i,
  input  logic                  configured_i,
  input  logic                  clr_toggle_i,
  input  logic [NUM_EP-1:0]     halt_i,
  input  logic                  tok_recv_i,
  input  logic [1:0]            tok_type_i,
  input  logic [6:0]            tok_addr_i,
  input  logic [3:0]            tok_endp_i,
  input  logic                  hsk_recv_i,
  input  logic [1:0]            hsk_type_i,
  output logic                  hsk_send_o,
  output logic [1:0]            hsk_type_o,
  input  logic                  hsk_sent_i,
  output logic                  usb_send_o,
  output logic [1:0]            usb_type_o,
  input  logic                  usb_busy_i,
  input  logic                  usb_sent_i,
  output logic                  usb_tvalid_o,
  input  logic                  usb_tready_i,
  output logic                  usb_tlast_o,
  output logic [7:0]            usb_tdata_o,
  input  logic [NUM_EP-1:0]     ep_rdy_i,
  input  logic [NUM_EP-1:0]     ep_tvalid_i,
  output logic [NUM_EP-1:0]     ep_tready_o,
  input  logic [NUM_EP-1:0]     ep_tlast_i,
  input  logic [8*NUM_EP-1:0]   ep_tdata_i,
  output logic [NUM_EP-1:0]     ep_commit_o,
  output logic [NUM_EP-1:0]     ep_abort_o,
  output logic                  busy_o,
  output logic [2:0]            dbg_state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HSK  = 3'd1,
    SEND = 3'd2,
    DATA = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        hsk_type_q, hsk_type_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_EP-1:0] toggle_q, toggle_d;
  logic [NUM_EP-1:0] sel_oh;
  logic              tok_in;

  assign tok_in = tok_recv_i && (tok_type_i == 2'b10) && configured_i &&
                  (tok_addr_i == usb_addr_i) && (tok_endp_i != 4'd0) &&
                  (tok_endp_i <= 4'(NUM_EP));

  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < NUM_EP; i++) sel_oh[i] = (sel_q == 4'(i));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      hsk_type_q <= '0;
      cnt_q      <= '0;
      toggle_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      hsk_type_q <= hsk_type_d;
      cnt_q      <= cnt_d;
      toggle_q   <= toggle_d;
    end
  end

  // Payload follows AXI-S: a byte moves on a cycle where tvalid and tready are both high;
  // in DATA the selected source sees the encoder's tready and the encoder sees that source's
  // tvalid/tlast/tdata unchanged, every other source is held off with tready low.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    hsk_type_d   = hsk_type_q;
    cnt_d        = cnt_q;
    toggle_d     = toggle_q;
    hsk_send_o   = 1'b0;
    hsk_type_o   = 2'b00;
    usb_send_o   = 1'b0;
    usb_type_o   = 2'b00;
    usb_tvalid_o = 1'b0;
    usb_tlast_o  = 1'b0;
    usb_tdata_o  = 8'h00;
    ep_tready_o  = '0;
    ep_commit_o  = '0;
    ep_abort_o   = '0;

    case (state_q)
      IDLE: begin
        if (tok_in) begin
          sel_d = tok_endp_i - 4'd1;
          for (int i = 0; i < NUM_EP; i++) begin
            if (tok_endp_i == 4'(i + 1)) begin
              if (halt_i[i]) begin
                state_d    = HSK;
                hsk_type_d = 2'b11;
              end else if (ep_rdy_i[i]) begin
                state_d = SEND;
              end else begin
                state_d    = HSK;
                hsk_type_d = 2'b10;
              end
            end
          end
        end
      end
      HSK: begin
        hsk_send_o = 1'b1;
        hsk_type_o = hsk_type_q;
        if (hsk_sent_i) state_d = IDLE;
      end
      SEND: begin
        usb_send_o = 1'b1;
        usb_type_o = (|(toggle_q & sel_oh)) ? 2'b10 : 2'b00;
        if (usb_busy_i) state_d = DATA;
      end
      DATA: begin
        usb_tvalid_o = |(ep_tvalid_i & sel_oh);
        usb_tlast_o  = |(ep_tlast_i & sel_oh);
        for (int i = 0; i < NUM_EP; i++) begin
          if (sel_oh[i]) usb_tdata_o = ep_tdata_i[8*i +: 8];
        end
        ep_tready_o = sel_oh & {NUM_EP{usb_tready_i}};
        if (usb_sent_i) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A handshake on the last timeout cycle still counts as an answer.
        if (hsk_recv_i) begin
          state_d = IDLE;
          if (hsk_type_i == 2'b00) begin
            ep_commit_o = sel_oh;
            toggle_d    = toggle_q ^ sel_oh;
          end else begin
            ep_abort_o = sel_oh;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          ep_abort_o = sel_oh;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr_toggle_i) toggle_d = '0;
  end

endmodule

// File: tb/tb_bulk_in_scheduler.sv
// Directed bench for bulk_in_scheduler: a vector table of IN/other tokens plus hand-written
// sequences for timeout, toggle clear, token during DATA and reset mid-transfer.
module tb_bulk_in_scheduler;

  localparam int R_NONE  = 0;
  localparam int R_NAK   = 1;
  localparam int R_STALL = 2;
  localparam int R_DATA  = 3;

  logic        clock;
  logic        reset;
  logic [6:0]  usb_addr_i;
  logic        configured_i;
  logic        clr_toggle_i;
  logic [1:0]  halt_i;
  logic        tok_recv_i;
  logic [1:0]  tok_type_i;
  logic [6:0]  tok_addr_i;
  logic [3:0]  tok_endp_i;
  logic        hsk_recv_i;
  logic [1:0]  hsk_type_i;
  logic        hsk_send_o;
  logic [1:0]  hsk_type_o;
  logic        hsk_sent_i;
  logic        usb_send_o;
  logic [1:0]  usb_type_o;
  logic        usb_busy_i;
  logic        usb_sent_i;
  logic        usb_tvalid_o;
  logic        usb_tready_i;
  logic        usb_tlast_o;
  logic [7:0]  usb_tdata_o;
  logic [1:0]  ep_rdy_i;
  logic [1:0]  ep_tvalid_i;
  logic [1:0]  ep_tready_o;
  logic [1:0]  ep_tlast_i;
  logic [15:0] ep_tdata_i;
  logic [1:0]  ep_commit_o;
  logic [1:0]  ep_abort_o;
  logic        busy_o;
  logic [2:0]  dbg_state_o;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [1:0]  commit_seen;
  logic [1:0]  abort_seen;

  bulk_in_scheduler #(.NUM_EP(2), .TIMEOUT(128)) dut (
    .clock(clock), .reset(reset), .usb_addr_i(usb_addr_i), .configured_i(configured_i),
    .clr_toggle_i(clr_toggle_i), .halt_i(halt_i), .tok_recv_i(tok_recv_i),
    .tok_type_i(tok_type_i), .tok_addr_i(tok_addr_i), .tok_endp_i(tok_endp_i),
    .hsk_recv_i(hsk_recv_i), .hsk_type_i(hsk_type_i), .hsk_send_o(hsk_send_o),
    .hsk_type_o(hsk_type_o), .hsk_sent_i(hsk_sent_i), .usb_send_o(usb_send_o),
    .usb_type_o(usb_type_o), .usb_busy_i(usb_busy_i), .usb_sent_i(usb_sent_i),
    .usb_tvalid_o(usb_tvalid_o), .usb_tready_i(usb_tready_i), .usb_tlast_o(usb_tlast_o),
    .usb_tdata_o(usb_tdata_o), .ep_rdy_i(ep_rdy_i), .ep_tvalid_i(ep_tvalid_i),
    .ep_tready_o(ep_tready_o), .ep_tlast_i(ep_tlast_i), .ep_tdata_i(ep_tdata_i),
    .ep_commit_o(ep_commit_o), .ep_abort_o(ep_abort_o), .busy_o(busy_o),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sticky record of commit/abort pulses, sampled mid low phase
  always begin
    @(negedge clock);
    #2;
    commit_seen = commit_seen | ep_commit_o;
    abort_seen  = abort_seen | ep_abort_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot(input int e);
    logic [1:0] oh;
    oh = '0;
    oh[e-1] = 1'b1;
    return oh;
  endfunction

  // driver tasks
  task automatic token(input logic [1:0] tt, input logic [6:0] a, input logic [3:0] e);
    @(negedge clock);
    tok_type_i = tt;
    tok_addr_i = a;
    tok_endp_i = e;
    tok_recv_i = 1'b1;
    @(negedge clock);
    tok_recv_i = 1'b0;
  endtask

  task automatic stream(input int n, input int nbytes);
    usb_busy_i = 1'b1;
    @(negedge clock);
    #1;
    chk("send_drops_in_data", {31'd0, usb_send_o}, 0);
    chk("busy_in_data", {31'd0, busy_o}, 1);
    for (int b = 0; b < nbytes; b++) begin
      ep_tdata_i   = 16'($urandom);
      ep_tvalid_i  = 2'b11;
      ep_tlast_i   = (b == nbytes - 1) ? onehot(n + 1) : ~onehot(n + 1);
      usb_tready_i = 1'b1;
      exp_q.push_back(ep_tdata_i[8*n +: 8]);
      #1;
      chk("usb_tvalid", {31'd0, usb_tvalid_o}, 1);
      chk("usb_tdata", {24'd0, usb_tdata_o}, {24'd0, exp_q.pop_front()});
      chk("usb_tlast", {31'd0, usb_tlast_o}, (b == nbytes - 1) ? 1 : 0);
      chk("ep_tready", {30'd0, ep_tready_o}, {30'd0, onehot(n + 1)});
      @(negedge clock);
    end
    ep_tvalid_i  = 2'b00;
    ep_tlast_i   = 2'b00;
    usb_tready_i = 1'b0;
    #1;
    chk("usb_tvalid_idle", {31'd0, usb_tvalid_o}, 0);
    chk("ep_tready_low", {30'd0, ep_tready_o}, 0);
    usb_sent_i = 1'b1;
    usb_busy_i = 1'b0;
    @(negedge clock);
    usb_sent_i = 1'b0;
  endtask

  task automatic reply(input logic [1:0] t, input logic clr, input logic [1:0] exp_c,
                       input logic [1:0] exp_a);
    @(negedge clock);
    hsk_recv_i   = 1'b1;
    hsk_type_i   = t;
    clr_toggle_i = clr;
    #1;
    chk("ep_commit", {30'd0, ep_commit_o}, {30'd0, exp_c});
    chk("ep_abort", {30'd0, ep_abort_o}, {30'd0, exp_a});
    @(negedge clock);
    hsk_recv_i   = 1'b0;
    clr_toggle_i = 1'b0;
    #1;
    chk("idle_after_hsk", {31'd0, busy_o}, 0);
  endtask

  task automatic data_txn(input int e, input logic [1:0] dt, input int nb,
                          input logic [1:0] ht, input logic clr);
    token(2'b10, 7'd5, 4'(e));
    #1;
    chk("txn_usb_send", {31'd0, usb_send_o}, 1);
    chk("txn_usb_type", {30'd0, usb_type_o}, {30'd0, dt});
    stream(e - 1, nb);
    reply(ht, clr, (ht == 2'b00) ? onehot(e) : 2'b00, (ht == 2'b00) ? 2'b00 : onehot(e));
  endtask

  typedef struct {
    logic [1:0] tt;
    logic [6:0] addr;
    logic [3:0] endp;
    logic       cfg;
    logic [1:0] rdy;
    logic [1:0] halt;
    int         resp;
    logic [1:0] dtype;
    int         nbytes;
    logic       ack;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [1:0] exp_c;
    logic [1:0] exp_a;
    logic [1:0] early;

    vecs[0]  = '{2'b10, 7'd5, 4'd1, 1'b1, 2'b01, 2'b00, R_DATA,  2'b00, 3, 1'b1};
    vecs[1]  = '{2'b10, 7'd5, 4'd1, 1'b1, 2'b01, 2'b00, R_DATA,  2'b10, 2, 1'b1};
    vecs[2]  = '{2'b10, 7'd5, 4'd2, 1'b1, 2'b00, 2'b00, R_NAK,   2'b00, 0, 1'b0};
    vecs[3]  = '{2'b10, 7'd5, 4'd2, 1'b1, 2'b11, 2'b10, R_STALL, 2'b00, 0, 1'b0};
    vecs[4]  = '{2'b10, 7'd5, 4'd2, 1'b1, 2'b11, 2'b00, R_DATA,  2'b00, 1, 1'b1};
    vecs[5]  = '{2'b10, 7'd6, 4'd1, 1'b1, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[6]  = '{2'b10, 7'd5, 4'd0, 1'b1, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[7]  = '{2'b10, 7'd5, 4'd3, 1'b1, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[8]  = '{2'b00, 7'd5, 4'd1, 1'b1, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[9]  = '{2'b11, 7'd5, 4'd1, 1'b1, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[10] = '{2'b10, 7'd5, 4'd1, 1'b0, 2'b11, 2'b00, R_NONE,  2'b00, 0, 1'b0};
    vecs[11] = '{2'b10, 7'd5, 4'd1, 1'b1, 2'b01, 2'b00, R_DATA,  2'b00, 2, 1'b0};
    vecs[12] = '{2'b10, 7'd5, 4'd1, 1'b1, 2'b01, 2'b00, R_DATA,  2'b00, 0, 1'b1};
    vecs[13] = '{2'b10, 7'd5, 4'd2, 1'b1, 2'b10, 2'b00, R_DATA,  2'b10, 1, 1'b1};

    reset = 1'b0; usb_addr_i = 7'd5; configured_i = 1'b1; clr_toggle_i = 1'b0;
    halt_i = 2'b00; tok_recv_i = 1'b0; tok_type_i = 2'b00; tok_addr_i = 7'd0;
    tok_endp_i = 4'd0; hsk_recv_i = 1'b0; hsk_type_i = 2'b00; hsk_sent_i = 1'b0;
    usb_busy_i = 1'b0; usb_sent_i = 1'b0; usb_tready_i = 1'b0; ep_rdy_i = 2'b00;
    ep_tvalid_i = 2'b00; ep_tlast_i = 2'b00; ep_tdata_i = 16'h0000;
    commit_seen = 2'b00; abort_seen = 2'b00;

    repeat (3) @(negedge clock);
    #1;
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_hsk_send", {31'd0, hsk_send_o}, 0);
    chk("rst_usb_send", {31'd0, usb_send_o}, 0);
    chk("rst_hsk_type", {30'd0, hsk_type_o}, 0);
    chk("rst_ep_tready", {30'd0, ep_tready_o}, 0);
    chk("rst_commit_abort", {28'd0, ep_commit_o, ep_abort_o}, 0);
    reset = 1'b1;

    for (int v = 0; v < 14; v++) begin
      configured_i = vecs[v].cfg;
      ep_rdy_i     = vecs[v].rdy;
      halt_i       = vecs[v].halt;
      commit_seen  = 2'b00;
      abort_seen   = 2'b00;
      exp_c = 2'b00;
      exp_a = 2'b00;
      token(vecs[v].tt, vecs[v].addr, vecs[v].endp);
      #1;
      chk($sformatf("v%0d_hsk_send", v), {31'd0, hsk_send_o},
          (vecs[v].resp == R_NAK || vecs[v].resp == R_STALL) ? 1 : 0);
      chk($sformatf("v%0d_usb_send", v), {31'd0, usb_send_o}, (vecs[v].resp == R_DATA) ? 1 : 0);
      chk($sformatf("v%0d_busy", v), {31'd0, busy_o}, (vecs[v].resp == R_NONE) ? 0 : 1);
      if (vecs[v].resp == R_NAK || vecs[v].resp == R_STALL) begin
        chk($sformatf("v%0d_hsk_type", v), {30'd0, hsk_type_o},
            (vecs[v].resp == R_NAK) ? 32'd2 : 32'd3);
        @(negedge clock);
        hsk_sent_i = 1'b1;
        @(negedge clock);
        hsk_sent_i = 1'b0;
        #1;
        chk($sformatf("v%0d_idle", v), {31'd0, busy_o}, 0);
      end else if (vecs[v].resp == R_DATA) begin
        chk($sformatf("v%0d_usb_type", v), {30'd0, usb_type_o}, {30'd0, vecs[v].dtype});
        stream(int'(vecs[v].endp) - 1, vecs[v].nbytes);
        if (vecs[v].ack) exp_c = onehot(int'(vecs[v].endp));
        else exp_a = onehot(int'(vecs[v].endp));
        reply(vecs[v].ack ? 2'b00 : 2'b10, 1'b0, exp_c, exp_a);
      end
      chk($sformatf("v%0d_commit_seen", v), {30'd0, commit_seen}, {30'd0, exp_c});
      chk($sformatf("v%0d_abort_seen", v), {30'd0, abort_seen}, {30'd0, exp_a});
    end

    configured_i = 1'b1;
    ep_rdy_i     = 2'b11;
    halt_i       = 2'b00;

    // timeout: toggle0 is 1, no handshake, abort on the 128th wait cycle, retry repeats DATA1
    token(2'b10, 7'd5, 4'd1);
    #1;
    chk("to_usb_type", {30'd0, usb_type_o}, 2);
    stream(0, 2);
    early = 2'b00;
    for (int k = 1; k <= 128; k++) begin
      #1;
      if (k < 128) early = early | ep_abort_o;
      else chk("to_abort_at_128", {30'd0, ep_abort_o}, 1);
      @(negedge clock);
    end
    #1;
    chk("to_idle", {31'd0, busy_o}, 0);
    chk("to_no_early_abort", {30'd0, early}, 0);
    data_txn(1, 2'b10, 1, 2'b00, 1'b0);

    // clear on the ACK cycle wins over the flip
    data_txn(1, 2'b00, 1, 2'b00, 1'b1);
    data_txn(1, 2'b00, 1, 2'b00, 1'b0);

    // second IN during DATA is dropped and does not change the selected source
    token(2'b10, 7'd5, 4'd1);
    #1;
    chk("dd_usb_type", {30'd0, usb_type_o}, 2);
    usb_busy_i = 1'b1;
    @(negedge clock);
    token(2'b10, 7'd5, 4'd2);
    #1;
    chk("dd_no_usb_send", {31'd0, usb_send_o}, 0);
    chk("dd_no_hsk_send", {31'd0, hsk_send_o}, 0);
    chk("dd_busy", {31'd0, busy_o}, 1);
    stream(0, 1);
    reply(2'b00, 1'b0, 2'b01, 2'b00);
    data_txn(2, 2'b00, 1, 2'b00, 1'b0);

    // reset mid-DATA clears outputs at once and returns toggles to DATA0
    data_txn(1, 2'b00, 1, 2'b00, 1'b0);
    token(2'b10, 7'd5, 4'd1);
    #1;
    chk("rd_usb_type", {30'd0, usb_type_o}, 2);
    usb_busy_i = 1'b1;
    @(negedge clock);
    ep_tvalid_i  = 2'b11;
    usb_tready_i = 1'b1;
    #1;
    chk("rd_tvalid_before", {31'd0, usb_tvalid_o}, 1);
    reset = 1'b0;
    #1;
    chk("rd_tvalid", {31'd0, usb_tvalid_o}, 0);
    chk("rd_ep_tready", {30'd0, ep_tready_o}, 0);
    chk("rd_busy", {31'd0, busy_o}, 0);
    chk("rd_sends", {30'd0, usb_send_o, hsk_send_o}, 0);
    usb_busy_i   = 1'b0;
    ep_tvalid_i  = 2'b00;
    usb_tready_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    data_txn(1, 2'b00, 1, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
